// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller with pipeline stall, timeout and sticky error
// Issues one request per access, stalls until mem_done, and parks in ERR until reset.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [15:0] AddrIn,
  input  logic [15:0] WriteDataIn,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        Stall,
  output logic [15:0] DMemDataOut,
  output logic        errOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       wr_pending_q, wr_pending_d;
  logic       err_q, err_d;

  logic acc;
  logic bad;
  logic issue;
  logic read_done;

  assign acc   = ValidIn & (MemReadIn | MemWriteIn);
  assign bad   = AddrIn[0] | (MemReadIn & MemWriteIn);
  assign issue = (state_q == S_IDLE) & acc & ~bad;

  // Address and data come straight from EX/MEM, which is frozen while stalled.
  assign mem_en    = issue;
  assign mem_wr    = issue & MemWriteIn;
  assign mem_addr  = AddrIn;
  assign mem_wdata = WriteDataIn;

  // A hit completes before wr_pending_q is loaded, so use the live opcode then.
  assign read_done = mem_done & ~mem_err &
                     ((issue & ~MemWriteIn) | ((state_q == S_BUSY) & ~wr_pending_q));
  assign DMemDataOut = read_done ? mem_rdata : 16'h0000;
  assign errOut      = err_q;

  always_comb begin
    Stall = 1'b1;
    case (state_q)
      S_IDLE:  Stall = acc & (bad | ~mem_done);
      S_BUSY:  Stall = ~mem_done;
      default: Stall = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_pending_d = wr_pending_q;
    case (state_q)
      S_IDLE: begin
        if (acc & bad) begin
          state_d = S_ERR;
        end else if (issue) begin
          wr_pending_d = MemWriteIn;
          if (mem_done) begin
            state_d = mem_err ? S_ERR : S_IDLE;
          end else begin
            state_d = S_BUSY;
            cnt_d   = 7'd0;
          end
        end
      end
      S_BUSY: begin
        // Completion on the final counted cycle beats the timeout.
        if (mem_done) begin
          state_d = mem_err ? S_ERR : S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = S_ERR;
    endcase
    err_d = err_q | (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 7'd0;
      wr_pending_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_pending_q <= wr_pending_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues loads and stores from the instruction in MEM to a multi-cycle data memory with a request/done handshake. While the access is outstanding it stalls the pipeline, and it presents load data to MEM/WB in the cycle the access completes. It detects misaligned addresses, memory-reported errors and access timeouts, and reports them as a sticky error that feeds the MEM/WB `errIn`.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles spent in BUSY before a timeout error; legal range 2..127.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `ValidIn`  in  1  instruction in MEM is valid (not a bubble).
- `MemReadIn`  in  1  instruction is a load.
- `MemWriteIn`  in  1  instruction is a store.
- `AddrIn`  in  16  byte address (EX result).
- `WriteDataIn`  in  16  store data.
- `mem_en`  out  1  memory request strobe.
- `mem_wr`  out  1  1 = write, 0 = read; valid when `mem_en`.
- `mem_addr`  out  16  request address.
- `mem_wdata`  out  16  request write data.
- `mem_rdata`  in  16  read data; valid when `mem_done`.
- `mem_done`  in  1  access complete (one-cycle pulse).
- `mem_err`  in  1  memory error; sampled only when `mem_done`.
- `Stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- `DMemDataOut`  out  16  load data to MEM/WB `DMemDataIn`.
- `errOut`  out  1  sticky error to MEM/WB `errIn`.

## Operation
- An access is `acc = ValidIn & (MemReadIn | MemWriteIn)`.
- If both `MemReadIn` and `MemWriteIn` are set, the access is treated as an error (same path as misaligned).
- States: IDLE, BUSY, ERR. There is also a counter `cnt` of 7 bits.
- IDLE:
  - If `acc` and `AddrIn[0]=1` (or read+write): no request. Next state is ERR.
  - Else if `acc`:
    - Drive `mem_en=1`, `mem_wr=MemWriteIn`, `mem_addr=AddrIn`, `mem_wdata=WriteDataIn` for this cycle only.
    - If `mem_done` arrives the same cycle (hit):
      - `mem_err=1` → ERR.
      - Otherwise stay in IDLE with `Stall=0`.
    - If `mem_done` does not arrive: go to BUSY, `cnt←0`.
  - If there is no `acc`: `mem_en=0`, and `mem_done` is ignored.
- BUSY:
  - `mem_en=0`.
  - On `mem_done` with `mem_err=0`: go to IDLE.
  - On `mem_done` with `mem_err=1`: go to ERR.
  - With no `mem_done`:
    - If `cnt==TIMEOUT-1`: go to ERR.
    - Else `cnt←cnt+1`.
- ERR: absorbing until `rst`. `mem_en=0`, `Stall=1`, `errOut=1`.
- `Stall` (combinational):
  - IDLE: `Stall = acc & ~mem_done`.
  - BUSY: `Stall = ~mem_done`.
  - ERR: `Stall = 1`.
  - A misaligned access in IDLE also drives `Stall=1`.
- `DMemDataOut` (combinational):
  - Equals `mem_rdata` in a completing cycle of a read (`mem_done & ~mem_wr_pending`).
  - Equals 0x0000 otherwise, including store completions.
  - `mem_wr_pending` is a register that captures `MemWriteIn` when the request is issued.
- EX/MEM inputs are stable while `Stall=1`, so the controller does not latch the address or data beyond `mem_wr_pending`.
- `errOut` is registered: `errOut=1` from the edge on which ERR is entered.

## Timing
- Reset values (async): state=IDLE, `cnt=0`, `mem_wr_pending=0`, `errOut=0`.
  - With no `acc`, the combinational outputs are then `mem_en=0`, `Stall=0`, `DMemDataOut=0`.
- Hit latency: 0 stall cycles. The load data is captured by MEM/WB at the end of the request cycle.
- Miss with `mem_done` N cycles after the request (N≥1): `Stall=1` for exactly N cycles. Data is valid and `Stall=0` in cycle N.
- Timeout: with no `mem_done`, BUSY lasts `TIMEOUT` cycles. `errOut` rises on the following edge.
- `mem_done` and `mem_err` in the same cycle: error wins. Data is not forwarded, and `DMemDataOut=0`.
- `mem_done` on the exact timeout cycle: the completion wins and there is no error.
- Reset asserted mid-BUSY: immediate return to IDLE.
  - The memory shares `rst`, so there is no stale `mem_done`.
  - Any `mem_done` in IDLE without `acc` is ignored.
- Back-to-back accesses: a new request may be issued in the IDLE cycle immediately following a BUSY completion.

## Test plan
- Load hit: `AddrIn=0x0010`, `MemReadIn=1`, `mem_done=1` same cycle, `mem_rdata=0xBEEF` → `mem_en=1`, `mem_wr=0`, `Stall=0`, `DMemDataOut=0xBEEF`; state stays IDLE.
- Store miss, done after 3 cycles: `AddrIn=0x0020`, `WriteDataIn=0x1234` → `mem_en` high for 1 cycle with `mem_wr=1`, `mem_wdata=0x1234`; `Stall=1` for 3 cycles; `DMemDataOut=0` at completion.
- Misaligned load `AddrIn=0x0021` → no `mem_en`; `Stall=1`; `errOut=1` from the next edge and held until `rst`.
- Timeout with `TIMEOUT=4`, no `mem_done` → exactly 4 BUSY cycles, then ERR; `errOut=1`; `Stall` stays 1.
- `mem_done=1` with `mem_err=1` in cycle 2 of a load → `DMemDataOut=0`, ERR entered, `errOut=1`.
- Async `rst` pulsed mid-BUSY (between edges) → state IDLE, `Stall=0`, and `errOut=0` immediately. A subsequent load hit to 0x0002 returns data normally.
